// File: rtl/sched_ctrl_if.sv
// Command port of the task-scheduler sequencer.
//   cmd_valid/cmd_ready : request handshake, a command is taken when both are high
//   cmd_op/cmd_tid      : operation code and target task id
//   cmd_info            : info/priority word, meaningful for CREATE
//   cmd_done/cmd_err    : completion pulse and its rejection flag
// master = command source, slave = sequencer.
interface sched_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_tid;
    logic [31:0] cmd_info;
    logic        cmd_done;
    logic        cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_tid, cmd_info,
        input  cmd_ready, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_tid, cmd_info,
        output cmd_ready, cmd_done, cmd_err
    );
endinterface

// File: rtl/sched_ctrl.sv
// Command sequencer and time-slice controller for the hardware task scheduler.
// Turns task commands into one-cycle one-hot pulses on the task-queue controls,
// waits for the queue/priority search to settle, samples the queue head and
// publishes the running task. A slice timer forces round-robin yields.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cmd               command port (sched_ctrl_if.slave)
//   task_info_new     info word of the last accepted CREATE
//   enqueue..que_blk  one-hot pulses to the task queue
//   qhead_tid         highest-priority ready tid from the queue
//   empty_flag        queue has no ready task
//   run_tid/run_valid currently dispatched task
//   ctx_switch        one-cycle pulse when {run_valid, run_tid} changes
//
// state      | meaning
// S_IDLE     | ready for a command; serves a pending slice expiry otherwise
// S_ISSUE    | legality check, one queue pulse, task table update
// S_REQUEUE  | yield only: re-enqueue the task that was just dequeued
// S_SETTLE   | wait SETTLE_CYC cycles for the queue search to settle
// S_DISPATCH | sample queue head, finish the command
module sched_ctrl #(
    parameter int NTASK      = 16,
    parameter int TSLICE     = 1000,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sched_ctrl_if.slave       cmd,
    output logic [31:0]       task_info_new,
    output logic [NTASK-1:0]  enqueue,
    output logic [NTASK-1:0]  dequeue,
    output logic [NTASK-1:0]  remove,
    output logic [NTASK-1:0]  que_act,
    output logic [NTASK-1:0]  que_blk,
    input  logic [3:0]        qhead_tid,
    input  logic              empty_flag,
    output logic [3:0]        run_tid,
    output logic              run_valid,
    output logic              ctx_switch
);

    localparam logic [2:0]  OP_CREATE  = 3'd0;
    localparam logic [2:0]  OP_BLOCK   = 3'd1;
    localparam logic [2:0]  OP_UNBLOCK = 3'd2;
    localparam logic [2:0]  OP_DELETE  = 3'd3;
    localparam logic [2:0]  OP_YIELD   = 3'd4;
    localparam logic [15:0] SLICE_LOAD  = 16'(TSLICE);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_REQUEUE,
        S_SETTLE,
        S_DISPATCH
    } state_t;

    typedef enum logic [1:0] {
        T_FREE,
        T_READY,
        T_BLOCKED
    } tstate_t;

    state_t      state, state_nxt;
    tstate_t     task_tbl [NTASK];
    logic [2:0]  op_q;
    logic [3:0]  tid_q;
    logic [31:0] info_q;
    logic        internal_q;
    logic        err_q;
    logic [15:0] settle_cnt;
    logic [15:0] slice_cnt;
    logic        expiry;

    logic        legal;
    logic        accept_ext;
    logic        accept_int;
    logic        new_valid;
    logic [3:0]  new_tid;
    logic        run_changed;
    logic        yield_done;

    always_comb begin
        legal = 1'b0;
        case (op_q)
            OP_CREATE:  legal = (task_tbl[tid_q] == T_FREE);
            OP_BLOCK:   legal = (task_tbl[tid_q] == T_READY);
            OP_UNBLOCK: legal = (task_tbl[tid_q] == T_BLOCKED);
            OP_DELETE:  legal = (task_tbl[tid_q] != T_FREE);
            OP_YIELD:   legal = run_valid;
            default:    legal = 1'b0;
        endcase
    end

    // An empty queue keeps the old tid and only drops run_valid, so the
    // change test sees the valid bit flip rather than a tid change.
    always_comb begin
        new_valid   = !empty_flag;
        new_tid     = empty_flag ? run_tid : qhead_tid;
        run_changed = ({new_valid, new_tid} != {run_valid, run_tid});
        yield_done  = (op_q == OP_YIELD) && !err_q;
    end

    always_comb begin
        state_nxt     = state;
        cmd.cmd_ready = 1'b0;
        cmd.cmd_done  = 1'b0;
        cmd.cmd_err   = 1'b0;
        enqueue       = '0;
        dequeue       = '0;
        remove        = '0;
        que_act       = '0;
        que_blk       = '0;
        accept_ext    = 1'b0;
        accept_int    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd.cmd_ready = 1'b1;
                // External command wins; a pending expiry waits for the next IDLE.
                if (cmd.cmd_valid) begin
                    accept_ext = 1'b1;
                    state_nxt  = S_ISSUE;
                end else if (expiry && run_valid) begin
                    accept_int = 1'b1;
                    state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!legal) begin
                    state_nxt = S_DISPATCH;
                end else begin
                    case (op_q)
                        OP_CREATE:  enqueue[tid_q]   = 1'b1;
                        OP_BLOCK:   que_blk[tid_q]   = 1'b1;
                        OP_UNBLOCK: que_act[tid_q]   = 1'b1;
                        OP_DELETE:  remove[tid_q]    = 1'b1;
                        OP_YIELD:   dequeue[run_tid] = 1'b1;
                        default:    ;
                    endcase
                    state_nxt = (op_q == OP_YIELD) ? S_REQUEUE : S_SETTLE;
                end
            end
            S_REQUEUE: begin
                enqueue[run_tid] = 1'b1;
                state_nxt        = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                cmd.cmd_done = !internal_q;
                cmd.cmd_err  = !internal_q && err_q;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            op_q          <= '0;
            tid_q         <= '0;
            info_q        <= '0;
            internal_q    <= 1'b0;
            err_q         <= 1'b0;
            settle_cnt    <= '0;
            for (int i = 0; i < NTASK; i++) begin
                task_tbl[i] <= T_FREE;
            end
            task_info_new <= '0;
            run_tid       <= '0;
            run_valid     <= 1'b0;
            ctx_switch    <= 1'b0;
            slice_cnt     <= SLICE_LOAD;
            expiry        <= 1'b0;
        end else begin
            state      <= state_nxt;
            ctx_switch <= 1'b0;

            if (accept_ext) begin
                op_q       <= cmd.cmd_op;
                tid_q      <= cmd.cmd_tid;
                info_q     <= cmd.cmd_info;
                internal_q <= 1'b0;
            end else if (accept_int) begin
                op_q       <= OP_YIELD;
                internal_q <= 1'b1;
            end

            if (state == S_ISSUE) begin
                err_q      <= !legal;
                settle_cnt <= SETTLE_LOAD;
                if (legal) begin
                    case (op_q)
                        OP_CREATE: begin
                            task_tbl[tid_q] <= T_READY;
                            task_info_new   <= info_q;
                        end
                        OP_BLOCK:   task_tbl[tid_q] <= T_BLOCKED;
                        OP_UNBLOCK: task_tbl[tid_q] <= T_READY;
                        OP_DELETE:  task_tbl[tid_q] <= T_FREE;
                        default:    ;
                    endcase
                end
            end else if (state == S_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 16'd1;
            end

            // Slice timer: reload on a new running task or a served yield,
            // park at TSLICE while idle, otherwise count down to a sticky expiry.
            if (state == S_DISPATCH && (run_changed || yield_done)) begin
                slice_cnt <= SLICE_LOAD;
                expiry    <= 1'b0;
            end else if (!run_valid) begin
                slice_cnt <= SLICE_LOAD;
            end else if (slice_cnt != '0) begin
                slice_cnt <= slice_cnt - 16'd1;
                if (slice_cnt == 16'd1) begin
                    expiry <= 1'b1;
                end
            end

            if (state == S_DISPATCH) begin
                run_valid  <= new_valid;
                run_tid    <= new_tid;
                ctx_switch <= run_changed;
            end
        end
    end

endmodule
